// File: rtl/video_rom_loader.sv
// Download-port loader for the video ROM regions: char banks, palette and PROM.
// Unpacks 16-bit download words into bytes, keeps per-region checksums, and serves registered read ports.
module video_rom_loader #(
  parameter int unsigned WIDE       = 1,
  parameter int unsigned AW_CHAR    = 12,
  parameter int unsigned AW_PAL     = 5,
  parameter int unsigned AW_PROM    = 7,
  parameter logic [26:0] BASE_CHAR1 = 27'h8000,
  parameter logic [26:0] BASE_CHAR2 = 27'h9000,
  parameter logic [26:0] BASE_PAL   = 27'hA000,
  parameter logic [26:0] BASE_PROM  = 27'hA020
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_download,
  input  logic [26:0]        ioctl_addr,
  input  logic [15:0]        ioctl_dout,
  input  logic               ioctl_wr,
  output logic               ioctl_wait,
  input  logic [AW_CHAR-1:0] char_addr,
  input  logic [AW_CHAR-1:0] spr_addr,
  output logic [7:0]         char_data1,
  output logic [7:0]         char_data2,
  output logic [7:0]         spr_data1,
  output logic [7:0]         spr_data2,
  input  logic [AW_PAL-1:0]  pal_addr,
  output logic [7:0]         pal_data,
  input  logic [AW_PROM-1:0] prom_addr,
  output logic [7:0]         prom_data,
  output logic [31:0]        sum,
  output logic               load_done
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t      state;
  logic [26:0] lat_addr;
  logic [15:0] lat_data;
  logic        dl_prev, seen, wait_q, done_q;
  logic [7:0]  sum_c1, sum_c2, sum_pal, sum_prom;

  logic [7:0] mem_c1   [0:(2**AW_CHAR)-1];
  logic [7:0] mem_c2   [0:(2**AW_CHAR)-1];
  logic [7:0] mem_pal  [0:(2**AW_PAL)-1];
  logic [7:0] mem_prom [0:(2**AW_PROM)-1];

  logic [7:0] q_c1a, q_c2a, q_c1b, q_c2b, q_pal, q_prom;

  function automatic logic in_region(input logic [26:0] a, input logic [26:0] base,
                                     input int unsigned aw);
    logic [27:0] x, lo, hi;
    x  = {1'b0, a};
    lo = {1'b0, base};
    hi = lo + (28'd1 << aw);
    return (x >= lo) && (x < hi);
  endfunction

  // Each byte of a word is decoded on its own, so a word may straddle two regions.
  logic [26:0] byte_addr;
  logic [7:0]  byte_data;
  logic        byte_wr;

  always_comb begin
    byte_wr   = (state != IDLE) && !reset;
    byte_addr = lat_addr;
    byte_data = lat_data[7:0];
    if (state == HI) begin
      byte_addr = lat_addr + 27'd1;
      byte_data = lat_data[15:8];
    end
  end

  logic wr_c1, wr_c2, wr_pal, wr_prom, clr;
  logic [AW_CHAR-1:0] off_c1, off_c2;
  logic [AW_PAL-1:0]  off_pal;
  logic [AW_PROM-1:0] off_prom;

  assign wr_c1    = byte_wr && in_region(byte_addr, BASE_CHAR1, AW_CHAR);
  assign wr_c2    = byte_wr && in_region(byte_addr, BASE_CHAR2, AW_CHAR);
  assign wr_pal   = byte_wr && in_region(byte_addr, BASE_PAL, AW_PAL);
  assign wr_prom  = byte_wr && in_region(byte_addr, BASE_PROM, AW_PROM);
  assign off_c1   = AW_CHAR'(byte_addr - BASE_CHAR1);
  assign off_c2   = AW_CHAR'(byte_addr - BASE_CHAR2);
  assign off_pal  = AW_PAL'(byte_addr - BASE_PAL);
  assign off_prom = AW_PROM'(byte_addr - BASE_PROM);
  assign clr      = ioctl_download && !dl_prev;

  always_ff @(posedge clk_sys) begin
    if (wr_c1)   mem_c1[off_c1]     <= byte_data;
    if (wr_c2)   mem_c2[off_c2]     <= byte_data;
    if (wr_pal)  mem_pal[off_pal]   <= byte_data;
    if (wr_prom) mem_prom[off_prom] <= byte_data;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      q_c1a  <= '0;
      q_c2a  <= '0;
      q_c1b  <= '0;
      q_c2b  <= '0;
      q_pal  <= '0;
      q_prom <= '0;
    end else begin
      q_c1a  <= mem_c1[char_addr];
      q_c2a  <= mem_c2[char_addr];
      q_c1b  <= mem_c1[spr_addr];
      q_c2b  <= mem_c2[spr_addr];
      q_pal  <= mem_pal[pal_addr];
      q_prom <= mem_prom[prom_addr];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      lat_addr <= '0;
      lat_data <= '0;
      dl_prev  <= 1'b0;
      seen     <= 1'b0;
      wait_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_c1   <= '0;
      sum_c2   <= '0;
      sum_pal  <= '0;
      sum_prom <= '0;
    end else begin
      dl_prev <= ioctl_download;
      done_q  <= 1'b0;
      // Completion waits for the FSM to drain so a trailing byte lands first.
      if (ioctl_download) begin
        seen <= 1'b1;
      end else if (state == IDLE && seen) begin
        done_q <= 1'b1;
        seen   <= 1'b0;
      end
      sum_c1   <= (clr ? 8'd0 : sum_c1)   + (wr_c1   ? byte_data : 8'd0);
      sum_c2   <= (clr ? 8'd0 : sum_c2)   + (wr_c2   ? byte_data : 8'd0);
      sum_pal  <= (clr ? 8'd0 : sum_pal)  + (wr_pal  ? byte_data : 8'd0);
      sum_prom <= (clr ? 8'd0 : sum_prom) + (wr_prom ? byte_data : 8'd0);
      case (state)
        IDLE: begin
          if (ioctl_download && ioctl_wr) begin
            lat_addr <= ioctl_addr;
            lat_data <= ioctl_dout;
            state    <= LO;
            wait_q   <= 1'b1;
          end
        end
        LO: begin
          if (WIDE != 0) begin
            state <= HI;
          end else begin
            state  <= IDLE;
            wait_q <= 1'b0;
          end
        end
        HI: begin
          state  <= IDLE;
          wait_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          wait_q <= 1'b0;
        end
      endcase
    end
  end

  assign ioctl_wait = wait_q;
  assign load_done  = done_q;
  assign sum        = {sum_prom, sum_pal, sum_c2, sum_c1};
  assign char_data1 = ioctl_download ? '0 : q_c1a;
  assign char_data2 = ioctl_download ? '0 : q_c2a;
  assign spr_data1  = ioctl_download ? '0 : q_c1b;
  assign spr_data2  = ioctl_download ? '0 : q_c2b;
  assign pal_data   = ioctl_download ? '0 : q_pal;
  assign prom_data  = ioctl_download ? '0 : q_prom;

endmodule
